// File: rtl/ifm_fetch_ctrl_pkg.sv
// Shared definitions for the IFM fetch controller: pixel width, fetch FSM
// state encoding and a constant-evaluable ceil(log2) helper for port widths.
package ifm_fetch_ctrl_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_t;

  // Width needed to count 0..value-1; never narrower than one bit.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/ifm_fetch_ctrl_addr_gen.sv
// Convolution-order address walker: x inside a kernel row, kr inside the
// kernel, r across output rows. Addresses come from row-base registers
// stepped by IFM_W, so no multiplier is needed.
module ifm_fetch_ctrl_addr_gen
  import ifm_fetch_ctrl_pkg::*;
#(
  parameter int IFM_W  = 8,
  parameter int IFM_H  = 8,
  parameter int KH     = 4,
  parameter int ADDR_W = 6,
  localparam int XW    = clog2(IFM_W),
  localparam int KRW   = clog2(KH),
  localparam int RW    = clog2(IFM_H - KH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic [XW-1:0]     col,
  output logic [KRW-1:0]    kr,
  output logic [RW-1:0]     row,
  output logic              last
);

  logic [ADDR_W-1:0] row_base;  // (row + kr) * IFM_W
  logic [ADDR_W-1:0] out_base;  // row * IFM_W

  logic col_end;
  logic kr_end;

  assign col_end = (col == XW'(IFM_W - 1));
  assign kr_end  = (kr == KRW'(KH - 1));
  assign last    = col_end && kr_end && (row == RW'(IFM_H - KH));
  assign addr    = row_base + ADDR_W'(col);

  // Step the walk on every issued read; wrap to zero after the final address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col      <= '0;
      kr       <= '0;
      row      <= '0;
      row_base <= '0;
      out_base <= '0;
    end else if (clear || (advance && last)) begin
      col      <= '0;
      kr       <= '0;
      row      <= '0;
      row_base <= '0;
      out_base <= '0;
    end else if (advance) begin
      if (col_end) begin
        col <= '0;
        if (kr_end) begin
          kr       <= '0;
          row      <= row + RW'(1);
          out_base <= out_base + ADDR_W'(IFM_W);
          row_base <= out_base + ADDR_W'(IFM_W);
        end else begin
          kr       <= kr + KRW'(1);
          row_base <= row_base + ADDR_W'(IFM_W);
        end
      end else begin
        col <= col + XW'(1);
      end
    end
  end

endmodule

// File: rtl/ifm_fetch_ctrl.sv
// IFM fetch controller: reads an IFM tile from single-port SRAM in
// convolution order and hands one pixel per ifm_read to the 4-tap buffer.
// Handshake: a read issued on sram_cs sets 'pending'; the SRAM holds its
// data until the next cs, so the pixel stays on ifm_input while pending.
// ifm_read = pending & ~stall consumes it; a new read may issue in the same
// cycle as a consume, giving one pixel per cycle with no stalls.
module ifm_fetch_ctrl
  import ifm_fetch_ctrl_pkg::*;
#(
  parameter int IFM_W  = 8,
  parameter int IFM_H  = 8,
  parameter int KW     = 4,
  parameter int KH     = 4,
  parameter int ADDR_W = 6,
  localparam int XW    = clog2(IFM_W),
  localparam int KRW   = clog2(KH),
  localparam int RW    = clog2(IFM_H - KH + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stall,
  output logic                     sram_cs,
  output logic [ADDR_W-1:0]        sram_addr,
  input  logic [DATA_W-1:0]        sram_rdata,
  output logic signed [DATA_W-1:0] ifm_input,
  output logic                     ifm_read,
  output logic                     win_valid,
  output logic [KRW-1:0]           kr_idx,
  output logic [RW-1:0]            row_idx,
  output logic                     busy,
  output logic                     done
);

  fetch_state_t state;
  fetch_state_t state_next;

  logic           pending;
  logic [XW-1:0]  tag_col;
  logic [KRW-1:0] tag_kr;
  logic [RW-1:0]  tag_row;

  logic [XW-1:0]  gen_col;
  logic [KRW-1:0] gen_kr;
  logic [RW-1:0]  gen_row;
  logic           gen_last;
  logic           start_accept;

  assign start_accept = (state == ST_IDLE) && start;

  ifm_fetch_ctrl_addr_gen #(
    .IFM_W  (IFM_W),
    .IFM_H  (IFM_H),
    .KH     (KH),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (start_accept),
    .advance (sram_cs),
    .addr    (sram_addr),
    .col     (gen_col),
    .kr      (gen_kr),
    .row     (gen_row),
    .last    (gen_last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state: leave FETCH once the last address issues, DRAIN once it is consumed.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (start) state_next = ST_FETCH;
      ST_FETCH: if (sram_cs && gen_last) state_next = ST_DRAIN;
      ST_DRAIN: if (ifm_read) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Outputs: handshake glue and status decoded from state and pending.
  always_comb begin
    ifm_read  = pending && !stall;
    sram_cs   = (state == ST_FETCH) && !stall && (!pending || ifm_read);
    ifm_input = pending ? signed'(sram_rdata) : '0;
    busy      = (state == ST_FETCH) || (state == ST_DRAIN);
    done      = (state == ST_DONE);
  end

  // Pending flag and the position tags of the pixel it refers to; issue wins over consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
      tag_col <= '0;
      tag_kr  <= '0;
      tag_row <= '0;
    end else if (sram_cs) begin
      pending <= 1'b1;
      tag_col <= gen_col;
      tag_kr  <= gen_kr;
      tag_row <= gen_row;
    end else if (ifm_read) begin
      pending <= 1'b0;
    end
  end

  // Window flag lines up with the buffer taps after the shift; indices follow the shifted pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid <= 1'b0;
      kr_idx    <= '0;
      row_idx   <= '0;
    end else begin
      win_valid <= ifm_read && (tag_col >= XW'(KW - 1));
      if (ifm_read) begin
        kr_idx  <= tag_kr;
        row_idx <= tag_row;
      end
    end
  end

endmodule

// File: tb/tb_ifm_fetch_ctrl.sv
// Bench for ifm_fetch_ctrl: table of whole-tile runs (stall profile,
// drain hold, stray start pulse, expected totals), plus hand sequences for
// reset state and a mid-tile reset. A negedge monitor compares every handed-
// over pixel and window index against an independently built expected queue.
module tb_ifm_fetch_ctrl;

  typedef struct packed {
    logic [7:0] pix;
    logic [2:0] col;
    logic [1:0] kr;
    logic [2:0] r;
  } exp_t;

  typedef struct {
    int stall_pct;
    int drain_hold;
    int extra_off;   // offset of a stray start pulse after the real one, 0 = none
    int exp_reads;
    int exp_wins;
    int exp_done_lat;  // -1 = not checked
  } vec_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              stall;
  logic              sram_cs;
  logic [5:0]        sram_addr;
  logic [7:0]        sram_rdata = 8'd0;
  logic signed [7:0] ifm_input;
  logic              ifm_read;
  logic              win_valid;
  logic [1:0]        kr_idx;
  logic [2:0]        row_idx;
  logic              busy;
  logic              done;

  logic [7:0] mem [0:63];
  exp_t       exp_q[$];
  vec_t       vecs[5];

  int  n_checks = 0;
  int  n_pass   = 0;
  int  cyc      = 0;
  int  start_cyc;
  int  read_cnt, win_cnt, done_cnt, done_cyc, first_read_cyc;
  bit  mon_en = 1'b0;
  bit  tb_p, exp_wv, last_issued;
  logic [1:0] exp_kr;
  logic [2:0] exp_r;

  ifm_fetch_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stall      (stall),
    .sram_cs    (sram_cs),
    .sram_addr  (sram_addr),
    .sram_rdata (sram_rdata),
    .ifm_input  (ifm_input),
    .ifm_read   (ifm_read),
    .win_valid  (win_valid),
    .kr_idx     (kr_idx),
    .row_idx    (row_idx),
    .busy       (busy),
    .done       (done)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: data one cycle after cs, held while cs is low
  always @(posedge clk) if (sram_cs) sram_rdata <= mem[sram_addr];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic load_exp();
    exp_t e;
    exp_q.delete();
    for (int r = 0; r <= 4; r++)
      for (int k = 0; k <= 3; k++)
        for (int x = 0; x <= 7; x++) begin
          e.pix = 8'((r + k) * 8 + x);
          e.col = 3'(x);
          e.kr  = 2'(k);
          e.r   = 3'(r);
          exp_q.push_back(e);
        end
  endtask

  task automatic clear_stats();
    read_cnt = 0; win_cnt = 0; done_cnt = 0; done_cyc = -1; first_read_cyc = -1;
    tb_p = 1'b0; exp_wv = 1'b0; last_issued = 1'b0;
  endtask

  // Monitor: pixel order, window timing/indices, stall and issue rules
  always @(negedge clk) begin
    exp_t e;
    bit   nxt_wv;
    if (mon_en) begin
      check("win_valid", int'(win_valid), int'(exp_wv));
      if (win_valid && exp_wv) begin
        check("kr_idx", int'(kr_idx), int'(exp_kr));
        check("row_idx", int'(row_idx), int'(exp_r));
        win_cnt++;
      end
      if (stall) check("read_under_stall", int'(ifm_read), 0);
      check("cs_while_pending", int'(sram_cs && tb_p && !ifm_read), 0);
      nxt_wv = 1'b0;
      if (ifm_read) begin
        if (read_cnt == 0) first_read_cyc = cyc;
        read_cnt++;
        if (exp_q.size() == 0) begin
          check("extra_pixel", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("pixel", int'($unsigned(ifm_input)), int'(e.pix));
          nxt_wv = (e.col >= 3'd3);
          exp_kr = e.kr;
          exp_r  = e.r;
        end
      end
      exp_wv = nxt_wv;
      tb_p = sram_cs ? 1'b1 : (ifm_read ? 1'b0 : tb_p);
      if (done) begin
        check("busy_at_done", int'(busy), 0);
        done_cnt++;
        done_cyc = cyc;
      end
      if (sram_cs && sram_addr == 6'd63) last_issued = 1'b1;
    end
  end

  task automatic run_tile(input vec_t v, input string tag);
    int  hold_left;
    bit  hold_used;
    bit  timed_out;
    load_exp();
    clear_stats();
    hold_left = 0;
    hold_used = 1'b0;
    timed_out = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; stall = 1'b0; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check({tag, "_busy_after_start"}, int'(busy), 1);
    check({tag, "_no_early_read"}, int'(ifm_read), 0);
    @(posedge clk); #1;
    for (int i = 0; i < 3000; i++) begin
      if (done_cnt > 0) begin timed_out = 1'b0; break; end
      start = (v.extra_off > 0 && cyc == start_cyc + v.extra_off);
      if (last_issued && v.drain_hold > 0 && !hold_used) begin
        hold_left = v.drain_hold;
        hold_used = 1'b1;
      end
      if (hold_left > 0) begin
        stall = 1'b1;
        hold_left--;
      end else begin
        stall = (v.stall_pct > 0) && ($urandom_range(0, 99) < v.stall_pct);
      end
      @(posedge clk); #1;
    end
    start = 1'b0; stall = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check({tag, "_timeout"}, int'(timed_out), 0);
    check({tag, "_reads"}, read_cnt, v.exp_reads);
    check({tag, "_wins"}, win_cnt, v.exp_wins);
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_left_in_queue"}, exp_q.size(), 0);
    check({tag, "_idle_busy"}, int'(busy), 0);
    if (v.stall_pct == 0) check({tag, "_first_read_lat"}, first_read_cyc - start_cyc, 2);
    if (v.exp_done_lat >= 0) check({tag, "_done_lat"}, done_cyc - start_cyc, v.exp_done_lat);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sram_cs"}, int'(sram_cs), 0);
    check({tag, "_sram_addr"}, int'(sram_addr), 0);
    check({tag, "_ifm_input"}, int'($unsigned(ifm_input)), 0);
    check({tag, "_ifm_read"}, int'(ifm_read), 0);
    check({tag, "_win_valid"}, int'(win_valid), 0);
    check({tag, "_kr_idx"}, int'(kr_idx), 0);
    check({tag, "_row_idx"}, int'(row_idx), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    vec_t rv;
    for (int a = 0; a < 64; a++) mem[a] = 8'(a);
    // stall%, drain hold, stray start offset, reads, windows, done latency
    vecs[0] = '{0,  0,  0,   160, 100, 162};
    vecs[1] = '{30, 0,  0,   160, 100, -1};
    vecs[2] = '{0,  10, 0,   160, 100, 172};
    vecs[3] = '{0,  0,  20,  160, 100, 162};
    vecs[4] = '{0,  0,  162, 160, 100, 162};

    rst_n = 1'b0; start = 1'b0; stall = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_tile(vecs[i], $sformatf("vec%0d", i));

    // Mid-tile reset after the 50th pixel, then a clean restart from address 0
    load_exp();
    clear_stats();
    mon_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (read_cnt >= 50) break;
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    mon_en = 1'b0;
    @(negedge clk);
    check_all_zero("abort");
    check("abort_reads", read_cnt, 50);
    check("abort_no_done", done_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rv = vecs[0];
    run_tile(rv, "restart");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time limit in case the design never finishes a tile
  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d checks, expected completion", n_checks);
    $fatal(1, "time limit");
  end

endmodule
